onehot_decoder_3to8_pulse: RTL and testbench
============================================

Name: onehot_decoder_3to8_pulse

Overview:
- Reverse direction of the 8-to-3 priority encoder: accepts a 3-bit code over a valid/ready handshake and drives the matching registered one-hot 8-bit line for a programmable number of cycles.
- A programmable idle gap follows each pulse.
- A one-entry skid buffer lets the upstream issue the next code while the current pulse is in progress.
- Used to drive per-line strobes (interrupt acks, lane selects) from encoded indices.

Parameters:
- HOLD_CYCLES, 4, cycles out_onehot/out_valid stay asserted per accepted code; legal 1..255.
- GAP_CYCLES, 1, all-zero cycles forced after each pulse; legal 0..255.
- CNT_W, 16, width of the completed-pulse counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a code.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  3  index 0..7 to decode.
- in_en  in  1  sampled with in_code. 0 = pulse occupies the slot but out_onehot stays 8'h00.
- out_onehot  out  8  registered one-hot output, bit in_code set.
- out_valid  out  1  high during every HOLD cycle, regardless of in_en.
- busy  out  1  state != IDLE or buffer full.
- pulse_count  out  CNT_W  completed pulses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, buffer empty.
  - out_onehot=8'h00, out_valid=0, busy=0, pulse_count=0, in_ready=1.
  - Reset mid-pulse aborts the pulse immediately and discards the buffered code; pulse_count is not incremented.
- Acceptance: a code is accepted on a rising edge when in_valid && in_ready.
  - in_ready = (state==IDLE) || !buf_full, derived from registered state only.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - On accept, next cycle: state=HOLD, out_valid=1, out_onehot=(in_en ? 1<<in_code : 0), hold counter loaded with HOLD_CYCLES-1.
  - Latency from accept edge to output is 1 cycle.
  - The buffer is always empty in IDLE.
- HOLD:
  - Counter decrements each cycle; out_valid is high for exactly HOLD_CYCLES cycles.
  - An accept during HOLD writes the buffer (code+en), sets buf_full, and drops in_ready the next cycle.
  - On the last HOLD cycle, pulse_count increments at that edge, and:
    - If GAP_CYCLES>0: go to GAP, outputs 0, gap counter loaded with GAP_CYCLES-1.
    - If GAP_CYCLES==0 and buf_full: go directly to a new HOLD with the buffered code. out_valid stays 1 and out_onehot switches to the new value with no bubble. The buffer empties.
    - If GAP_CYCLES==0 and buffer empty: go to IDLE.
- GAP:
  - Outputs are 0 for exactly GAP_CYCLES cycles.
  - Accepts into the buffer are allowed while it is empty.
  - On the last GAP cycle: go to HOLD with the buffered code if buf_full (buffer empties), else go to IDLE.
- Simultaneous events:
  - Buffer load into HOLD and a new upstream offer in the same cycle: the offer is not accepted, because in_ready was 0 with buf_full=1. in_ready rises the following cycle.
  - At most one accept per cycle.
  - A code offered while in_ready=0 must be held by upstream (standard valid/ready: in_valid stays high and in_code stays stable until accepted).
- Invariants:
  - out_onehot is either 0 or exactly one bit set.
  - out_onehot is nonzero only when out_valid=1.

Test Plan:
- Reset, HOLD_CYCLES=4, GAP_CYCLES=1; offer code 3'd5 with en=1 -> 1 cycle later out_onehot=8'h20 and out_valid=1 for 4 cycles, then 1 cycle of 8'h00, then IDLE. pulse_count=1.
- Offer 3'd0 then 3'd7 back-to-back (second held until in_ready) -> second is accepted into the buffer during HOLD. Output is 8'h01 x4, 8'h00 x1, 8'h80 x4 with no IDLE cycle between. in_ready is low from the cycle after the buffer write until the cycle after the buffer load.
- GAP_CYCLES=0, codes 3'd2 then 3'd3 -> out_valid continuously high for 8 cycles, out_onehot 8'h04 x4 then 8'h08 x4. pulse_count=2.
- Code 3'd6 with en=0 -> out_valid high 4 cycles with out_onehot=8'h00. pulse_count increments.
- Assert rst in the 2nd HOLD cycle with a buffered code -> outputs 0 asynchronously. After release: IDLE, in_ready=1, pulse_count=0, the buffered code is never output.
- CNT_W=4, issue 17 pulses -> pulse_count reads 4'd1 after the 17th pulse completes (wrap).

Source files
------------

// File: rtl/onehot_decoder_3to8_pulse.sv
// Decodes a 3-bit code into a registered one-hot strobe held for HOLD_CYCLES, followed by GAP_CYCLES idle.
// Latency: 1 cycle from the accept edge to out_onehot/out_valid.
// Backpressure: in_ready drops only while a pulse is running and the one-entry skid buffer is full.
module onehot_decoder_3to8_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             in_en,
  output logic [7:0]       out_onehot,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit         HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] cnt;
  logic       buf_full;
  logic [2:0] buf_code;
  logic       buf_en;
  logic       accept;
  logic       last;

  // Ready and busy come from registered state only, so no combinational path from in_valid.
  assign in_ready = (state == IDLE) || !buf_full;
  assign busy     = (state != IDLE) || buf_full;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == 8'd0);

  function automatic logic [7:0] decode(input logic [2:0] code, input logic en);
    decode = en ? (8'd1 << code) : 8'd0;
  endfunction

  // Pulse sequencer: IDLE -> HOLD -> (GAP) -> HOLD/IDLE, with the skid buffer feeding back-to-back pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      buf_full    <= 1'b0;
      buf_code    <= 3'd0;
      buf_en      <= 1'b0;
      out_onehot  <= 8'h00;
      out_valid   <= 1'b0;
      pulse_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= HOLD;
            cnt        <= HOLD_LOAD;
            out_valid  <= 1'b1;
            out_onehot <= decode(in_code, in_en);
          end
        end

        HOLD: begin
          if (!last) begin
            cnt <= cnt - 8'd1;
            if (accept) begin
              buf_full <= 1'b1;
              buf_code <= in_code;
              buf_en   <= in_en;
            end
          end else begin
            pulse_count <= pulse_count + CNT_ONE;
            if (HAS_GAP) begin
              state      <= GAP;
              cnt        <= GAP_LOAD;
              out_valid  <= 1'b0;
              out_onehot <= 8'h00;
              if (accept) begin
                buf_full <= 1'b1;
                buf_code <= in_code;
                buf_en   <= in_en;
              end
            end else if (buf_full) begin
              // No gap: chain straight into the buffered pulse without a bubble.
              cnt        <= HOLD_LOAD;
              out_onehot <= decode(buf_code, buf_en);
              buf_full   <= 1'b0;
            end else if (accept) begin
              // Empty buffer and a code arriving on the last cycle: start it directly.
              cnt        <= HOLD_LOAD;
              out_onehot <= decode(in_code, in_en);
            end else begin
              state      <= IDLE;
              out_valid  <= 1'b0;
              out_onehot <= 8'h00;
            end
          end
        end

        GAP: begin
          if (!last) begin
            cnt <= cnt - 8'd1;
            if (accept) begin
              buf_full <= 1'b1;
              buf_code <= in_code;
              buf_en   <= in_en;
            end
          end else if (buf_full) begin
            state      <= HOLD;
            cnt        <= HOLD_LOAD;
            out_valid  <= 1'b1;
            out_onehot <= decode(buf_code, buf_en);
            buf_full   <= 1'b0;
          end else if (accept) begin
            // Code arriving on the last gap cycle goes straight to HOLD so IDLE never holds a code.
            state      <= HOLD;
            cnt        <= HOLD_LOAD;
            out_valid  <= 1'b1;
            out_onehot <= decode(in_code, in_en);
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          out_onehot <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_3to8_pulse.sv
// Randomized bench for onehot_decoder_3to8_pulse with three parameter sets checked against a pulse-timeline model.
// Each accepted code is scheduled at max(accept+1, end of previous pulse+gap); outputs follow from that schedule.
// Upstream holds an unaccepted offer stable until it is taken.
module tb_onehot_decoder_3to8_pulse;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv [3];
  logic       ir [3];
  logic [2:0] code [3];
  logic       en [3];
  logic [7:0] oh [3];
  logic       ov [3];
  logic       bz [3];
  logic [15:0] pc0, pc1;
  logic [3:0]  pc2;

  onehot_decoder_3to8_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_code(code[0]), .in_en(en[0]),
    .out_onehot(oh[0]), .out_valid(ov[0]), .busy(bz[0]), .pulse_count(pc0));

  onehot_decoder_3to8_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_code(code[1]), .in_en(en[1]),
    .out_onehot(oh[1]), .out_valid(ov[1]), .busy(bz[1]), .pulse_count(pc1));

  onehot_decoder_3to8_pulse #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_code(code[2]), .in_en(en[2]),
    .out_onehot(oh[2]), .out_valid(ov[2]), .busy(bz[2]), .pulse_count(pc2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: scheduled pulses (start cycle and {en,code}) per instance.
  int         q_start [3][$];
  logic [3:0] q_tok   [3][$];
  int         free_at [3];
  int         mcount  [3];
  bit         hold    [3];
  int         cyc = 0;

  function automatic int hcyc(input int i);
    return (i == 2) ? 3 : 4;
  endfunction
  function automatic int gcyc(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction
  function automatic int cmask(input int i);
    return (i == 2) ? 32'hF : 32'hFFFF;
  endfunction
  function automatic logic [31:0] pc_of(input int i);
    return (i == 0) ? {16'h0, pc0} : ((i == 1) ? {16'h0, pc1} : {28'h0, pc2});
  endfunction

  function automatic bit model_ready(input int i);
    return (q_start[i].size() == 0) || (q_start[i][q_start[i].size()-1] <= cyc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q_start[i].delete();
      q_tok[i].delete();
      free_at[i] = 0;
      mcount[i]  = 0;
      hold[i]    = 1'b0;
      iv[i]      = 1'b0;
    end
  endtask

  // Advance one clock edge in the model: pulses whose HOLD ended are counted and dropped.
  task automatic retire();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      while (q_start[i].size() > 0 && q_start[i][0] + hcyc(i) <= cyc) begin
        void'(q_start[i].pop_front());
        void'(q_tok[i].pop_front());
        mcount[i] = (mcount[i] + 1) & cmask(i);
      end
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [7:0] eoh;
    for (int i = 0; i < 3; i++) begin
      ev  = (q_start[i].size() > 0) && (q_start[i][0] <= cyc);
      eoh = (ev && q_tok[i][0][3]) ? (8'd1 << q_tok[i][0][2:0]) : 8'd0;
      chk($sformatf("i%0d_out_valid", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("i%0d_out_onehot", i), 32'(oh[i]), 32'(eoh));
      chk($sformatf("i%0d_in_ready", i), 32'(ir[i]), 32'(model_ready(i)));
      chk($sformatf("i%0d_busy", i), 32'(bz[i]), 32'(cyc < free_at[i]));
      chk($sformatf("i%0d_pulse_count", i), pc_of(i), 32'(mcount[i]));
      chk($sformatf("i%0d_onehot0", i), 32'($onehot0(oh[i])), 32'd1);
      chk($sformatf("i%0d_oh_without_valid", i), 32'((oh[i] != 8'h00) && !ov[i]), 32'd0);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_rst_valid", i), 32'(ov[i]), 32'd0);
      chk($sformatf("i%0d_rst_onehot", i), 32'(oh[i]), 32'd0);
      chk($sformatf("i%0d_rst_count", i), pc_of(i), 32'd0);
      chk($sformatf("i%0d_rst_ready", i), 32'(ir[i]), 32'd1);
      chk($sformatf("i%0d_rst_busy", i), 32'(bz[i]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    retire();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  rate;
    int  st;
    bit  acc;
    bit  did_dir_rst;
    bit  saw_dir5;
    did_dir_rst = 1'b0;
    saw_dir5    = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; code[i] = 3'd0; en[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      check_all();
      if (n == 1) begin
        chk("dir_code5_onehot", 32'(oh[0]), 32'h20);
        saw_dir5 = 1'b1;
      end
      // Directed: reset in the second HOLD cycle of instance 0 while a code sits in its buffer.
      if ((!did_dir_rst && n > 20 && q_start[0].size() == 2 && q_start[0][0] == cyc - 1) ||
          ($urandom_range(499) == 0)) begin
        if (q_start[0].size() == 2 && q_start[0][0] == cyc - 1) did_dir_rst = 1'b1;
        do_reset();
        continue;
      end
      rate = ((n / 200) % 3 == 0) ? 90 : (((n / 200) % 3 == 1) ? 40 : 10);
      for (int i = 0; i < 3; i++) begin
        if (n == 0) begin
          iv[i] = 1'b1; code[i] = 3'd5; en[i] = 1'b1;
        end else if (!hold[i]) begin
          iv[i]   = ($urandom_range(99) < rate);
          code[i] = 3'($urandom_range(7));
          en[i]   = ($urandom_range(3) != 0);
        end
        acc = iv[i] && model_ready(i);
        if (acc) begin
          st = (cyc + 1 > free_at[i]) ? cyc + 1 : free_at[i];
          q_start[i].push_back(st);
          q_tok[i].push_back({en[i], code[i]});
          free_at[i] = st + hcyc(i) + gcyc(i);
        end
        hold[i] = iv[i] && !acc;
      end
      @(posedge clk);
      retire();
      @(negedge clk);
    end

    chk("directed_reset_reached", 32'(did_dir_rst), 32'd1);
    chk("directed_code5_reached", 32'(saw_dir5), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
